// File: rtl/led_pkg.sv
// Shared constants and FSM state encoding for the LED frame builder.
package led_pkg;

  localparam int LED_NUM = 4;
  localparam int PIX_W   = 32;
  localparam int FRAME_W = LED_NUM * PIX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } led_state_e;

endpackage

// File: rtl/led_cnt.sv
// Loadable down-counter that stops at zero; done_o flags the zero state.
// One instance paces both the enable pulse and the serializer busy gap.
module led_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  // Load takes priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/led_frame_builder.sv
// Collects four 32-bit LED words into a shadow buffer and hands complete
// frames to a downstream serializer, on commit or on a periodic refresh.
module led_frame_builder
  import led_pkg::*;
#(
  parameter int PULSE_CYC   = 16,
  parameter int GAP_CYC     = 1024,
  parameter int REFRESH_CYC = 150000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [1:0]         wr_idx,
  input  logic [PIX_W-1:0]   wr_data,
  input  logic               commit,
  input  logic               auto_en,
  output logic               enable_o,
  output logic [FRAME_W-1:0] data_o,
  output logic [15:0]        frame_cnt
);

  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMR_W   = $clog2(REFRESH_CYC + 1);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(REFRESH_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = {{(TMR_W-1){1'b0}}, 1'b1};

  led_state_e         state_q, state_d;
  logic               pending_q, pending_d;
  logic [TMR_W-1:0]   refreshTmr_q, refreshTmr_d;
  logic               tmrTick;
  logic [PIX_W-1:0]   shadow_q [LED_NUM];
  logic [FRAME_W-1:0] shadowFrame;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [15:0]        frameCnt_q, frameCnt_d;
  logic               wrReady_q;
  logic               wrAccept;
  logic               cntLoad;
  logic [CNT_W-1:0]   cntVal;
  logic               cntDone;

  led_cnt #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (cntLoad),
    .load_val_i (cntVal),
    .done_o     (cntDone)
  );

  assign wrAccept  = wr_valid & wrReady_q;
  assign wr_ready  = wrReady_q;
  assign enable_o  = (state_q == PULSE);
  assign data_o    = frame_q;
  assign frame_cnt = frameCnt_q;

  // Refresh timer free-runs modulo REFRESH_CYC and ticks on its last count.
  always_comb begin
    tmrTick      = (refreshTmr_q == TMR_LAST);
    refreshTmr_d = tmrTick ? '0 : refreshTmr_q + TMR_ONE;
  end

  // LED0 lands in the MSBs so the serializer shifts it out first.
  always_comb begin
    shadowFrame = '0;
    for (int i = 0; i < LED_NUM; i++) begin
      shadowFrame[FRAME_W-1-PIX_W*i -: PIX_W] = shadow_q[i];
    end
  end

  // Frame FSM; a request arriving during LOAD survives the clear, so it queues one more frame.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    frame_d    = frame_q;
    frameCnt_d = frameCnt_q;
    cntLoad    = 1'b0;
    cntVal     = PULSE_LOAD;
    case (state_q)
      IDLE: begin
        if (pending_q) state_d = LOAD;
      end
      LOAD: begin
        frame_d    = shadowFrame;
        pending_d  = 1'b0;
        frameCnt_d = frameCnt_q + 16'd1;
        cntLoad    = 1'b1;
        cntVal     = PULSE_LOAD;
        state_d    = PULSE;
      end
      PULSE: begin
        if (cntDone) begin
          cntLoad = 1'b1;
          cntVal  = GAP_LOAD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cntDone) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (commit || (tmrTick && auto_en)) pending_d = 1'b1;
  end

  // State, shadow buffer and output registers; wr_ready stays low while in reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      refreshTmr_q <= '0;
      frame_q      <= '0;
      frameCnt_q   <= '0;
      wrReady_q    <= 1'b0;
      for (int i = 0; i < LED_NUM; i++) shadow_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      refreshTmr_q <= refreshTmr_d;
      frame_q      <= frame_d;
      frameCnt_q   <= frameCnt_d;
      wrReady_q    <= (state_d != LOAD);
      if (wrAccept) shadow_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_led_frame_builder.sv
// Directed self-checking bench for led_frame_builder with short timing parameters.
module tb_led_frame_builder;

  localparam int PULSE_CYC   = 16;
  localparam int GAP_CYC     = 64;
  localparam int REFRESH_CYC = 2000;

  logic         clk = 1'b0;
  logic         rstn;
  logic         wr_valid;
  logic         wr_ready;
  logic [1:0]   wr_idx;
  logic [31:0]  wr_data;
  logic         commit;
  logic         auto_en;
  logic         enable_o;
  logic [127:0] data_o;
  logic [15:0]  frame_cnt;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [15:0] expCnt;

  led_frame_builder #(
    .PULSE_CYC   (PULSE_CYC),
    .GAP_CYC     (GAP_CYC),
    .REFRESH_CYC (REFRESH_CYC)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .commit    (commit),
    .auto_en   (auto_en),
    .enable_o  (enable_o),
    .data_o    (data_o),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic writePix(input logic [1:0] idx, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_idx   = idx;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pulseCommit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic waitEnable(input logic level, input int bound, output int waited);
    waited = 0;
    while (enable_o !== level && waited < bound) begin
      step();
      waited++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; wr_valid = 1'b0; wr_idx = 2'd0; wr_data = '0; commit = 1'b0; auto_en = 1'b0;
    step_n(5);
    testsRun++;
    if (enable_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_enable: got %b want 0", enable_o); end
    testsRun++;
    if (data_o !== 128'h0) begin testsFailed++; $display("[TB] FAIL reset_data: got %h want 0", data_o); end
    testsRun++;
    if (frame_cnt !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_cnt: got %h want 0", frame_cnt); end
    testsRun++;
    if (wr_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ready_low: got %b want 0", wr_ready); end
    rstn = 1'b1;
    step();
    testsRun++;
    if (wr_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready_release: got %b want 1", wr_ready); end
    expCnt = 16'h0;
  endtask

  task automatic test_single_frame();
    int n;
    for (int i = 0; i < 4; i++) writePix(2'(i), 32'h55555555);
    pulseCommit();
    step();
    testsRun++;
    if (enable_o !== 1'b0 || wr_ready !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL single_load_cycle: enable %b ready %b want 0 0", enable_o, wr_ready);
    end
    step();
    expCnt++;
    testsRun++;
    if (enable_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_enable_rise: got %b want 1", enable_o); end
    testsRun++;
    if (data_o !== {4{32'h55555555}}) begin testsFailed++; $display("[TB] FAIL single_data: got %h want 5555..55", data_o); end
    testsRun++;
    if (frame_cnt !== expCnt) begin testsFailed++; $display("[TB] FAIL single_cnt: got %h want %h", frame_cnt, expCnt); end
    n = 0;
    while (enable_o === 1'b1 && n < 40) begin n++; step(); end
    testsRun++;
    if (n != PULSE_CYC) begin testsFailed++; $display("[TB] FAIL single_pulse_len: got %0d want %0d", n, PULSE_CYC); end
    step_n(30);
    testsRun++;
    if (data_o !== {4{32'h55555555}}) begin testsFailed++; $display("[TB] FAIL single_gap_hold: got %h", data_o); end
    step_n(40);
    testsRun++;
    if (enable_o !== 1'b0 || frame_cnt !== expCnt) begin
      testsFailed++; $display("[TB] FAIL single_idle: enable %b cnt %h want 0 %h", enable_o, frame_cnt, expCnt);
    end
  endtask

  task automatic test_led_ordering();
    writePix(2'd0, 32'hAAAAAAAA);
    writePix(2'd3, 32'h00000001);
    pulseCommit();
    step_n(2);
    expCnt++;
    testsRun++;
    if (data_o[127:96] !== 32'hAAAAAAAA) begin testsFailed++; $display("[TB] FAIL order_msb: got %h want AAAAAAAA", data_o[127:96]); end
    testsRun++;
    if (data_o[31:0] !== 32'h00000001) begin testsFailed++; $display("[TB] FAIL order_lsb: got %h want 00000001", data_o[31:0]); end
    testsRun++;
    if (data_o !== 128'hAAAAAAAA_55555555_55555555_00000001) begin
      testsFailed++; $display("[TB] FAIL order_frame: got %h", data_o);
    end
    step_n(90);
  endtask

  task automatic test_write_with_commit();
    wr_valid = 1'b1; wr_idx = 2'd2; wr_data = 32'hCAFEF00D; commit = 1'b1;
    step();
    wr_valid = 1'b0; commit = 1'b0;
    step_n(2);
    expCnt++;
    testsRun++;
    if (data_o !== 128'hAAAAAAAA_55555555_CAFEF00D_00000001) begin
      testsFailed++; $display("[TB] FAIL same_cycle_write: got %h", data_o);
    end
    testsRun++;
    if (frame_cnt !== expCnt) begin testsFailed++; $display("[TB] FAIL same_cycle_cnt: got %h want %h", frame_cnt, expCnt); end
    step_n(90);
  endtask

  task automatic test_busy_collapse();
    int w;
    pulseCommit();
    step_n(2);
    expCnt++;
    step_n(PULSE_CYC);
    testsRun++;
    if (enable_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL busy_in_gap: enable %b want 0", enable_o); end
    pulseCommit();
    step_n(5);
    writePix(2'd1, 32'h12345678);
    testsRun++;
    if (data_o !== 128'hAAAAAAAA_55555555_CAFEF00D_00000001) begin
      testsFailed++; $display("[TB] FAIL busy_gap_write_leak: got %h", data_o);
    end
    step_n(3);
    pulseCommit();
    pulseCommit();
    waitEnable(1'b1, 100, w);
    testsRun++;
    if (enable_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL busy_extra_frame: enable %b want 1 after %0d", enable_o, w); end
    expCnt++;
    testsRun++;
    if (data_o !== 128'hAAAAAAAA_12345678_CAFEF00D_00000001) begin
      testsFailed++; $display("[TB] FAIL busy_data: got %h", data_o);
    end
    testsRun++;
    if (frame_cnt !== expCnt) begin testsFailed++; $display("[TB] FAIL busy_cnt: got %h want %h", frame_cnt, expCnt); end
    waitEnable(1'b0, 40, w);
    testsRun++;
    if (w != PULSE_CYC) begin testsFailed++; $display("[TB] FAIL busy_pulse_len: got %0d want %0d", w, PULSE_CYC); end
    waitEnable(1'b1, 100, w);
    testsRun++;
    if (enable_o !== 1'b0 || frame_cnt !== expCnt) begin
      testsFailed++; $display("[TB] FAIL busy_no_third: enable %b cnt %h want 0 %h", enable_o, frame_cnt, expCnt);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    commit = 1'b1;
    step();
    commit = 1'b0;
    step();
    commit = 1'b1;
    step();
    commit = 1'b0;
    expCnt++;
    testsRun++;
    if (enable_o !== 1'b1 || frame_cnt !== expCnt) begin
      testsFailed++; $display("[TB] FAIL b2b_first: enable %b cnt %h want 1 %h", enable_o, frame_cnt, expCnt);
    end
    waitEnable(1'b0, 40, w);
    waitEnable(1'b1, 100, w);
    testsRun++;
    if (enable_o !== 1'b1 || w != GAP_CYC + 2) begin
      testsFailed++; $display("[TB] FAIL b2b_second: enable %b after %0d want 1 after %0d", enable_o, w, GAP_CYC + 2);
    end
    expCnt++;
    testsRun++;
    if (frame_cnt !== expCnt) begin testsFailed++; $display("[TB] FAIL b2b_cnt: got %h want %h", frame_cnt, expCnt); end
    waitEnable(1'b0, 40, w);
    waitEnable(1'b1, 150, w);
    testsRun++;
    if (enable_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_no_third: enable %b want 0", enable_o); end
  endtask

  task automatic test_frame_cnt_wrap();
    force dut.frameCnt_q = 16'hFFFF;
    step_n(2);
    release dut.frameCnt_q;
    step();
    testsRun++;
    if (frame_cnt !== 16'hFFFF) begin testsFailed++; $display("[TB] FAIL wrap_preload: got %h want FFFF", frame_cnt); end
    pulseCommit();
    step_n(2);
    testsRun++;
    if (frame_cnt !== 16'h0000) begin testsFailed++; $display("[TB] FAIL wrap_cnt: got %h want 0000", frame_cnt); end
    expCnt = 16'h0000;
    step_n(90);
  endtask

  task automatic test_auto_refresh();
    int w;
    auto_en = 1'b1;
    waitEnable(1'b1, 2200, w);
    testsRun++;
    if (enable_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL auto_first: enable %b want 1", enable_o); end
    expCnt++;
    testsRun++;
    if (frame_cnt !== expCnt) begin testsFailed++; $display("[TB] FAIL auto_cnt: got %h want %h", frame_cnt, expCnt); end
    waitEnable(1'b0, 40, w);
    waitEnable(1'b1, 2200, w);
    testsRun++;
    if (enable_o !== 1'b1 || w + PULSE_CYC != REFRESH_CYC) begin
      testsFailed++; $display("[TB] FAIL auto_period: enable %b period %0d want 1 %0d", enable_o, w + PULSE_CYC, REFRESH_CYC);
    end
    expCnt++;
    auto_en = 1'b0;
    waitEnable(1'b0, 40, w);
    waitEnable(1'b1, 4500, w);
    testsRun++;
    if (enable_o !== 1'b0 || frame_cnt !== expCnt) begin
      testsFailed++; $display("[TB] FAIL auto_disabled: enable %b cnt %h want 0 %h", enable_o, frame_cnt, expCnt);
    end
  endtask

  task automatic test_reset_mid_pulse();
    pulseCommit();
    step_n(7);
    testsRun++;
    if (enable_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_pre: enable %b want 1", enable_o); end
    rstn = 1'b0;
    step();
    testsRun++;
    if (enable_o !== 1'b0 || data_o !== 128'h0) begin
      testsFailed++; $display("[TB] FAIL midrst_abort: enable %b data %h want 0 0", enable_o, data_o);
    end
    testsRun++;
    if (frame_cnt !== 16'h0 || wr_ready !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL midrst_state: cnt %h ready %b want 0 0", frame_cnt, wr_ready);
    end
    step_n(4);
    rstn = 1'b1;
    step();
    testsRun++;
    if (wr_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_ready: got %b want 1", wr_ready); end
    writePix(2'd0, 32'hDEADBEEF);
    pulseCommit();
    step_n(2);
    testsRun++;
    if (data_o !== 128'hDEADBEEF_00000000_00000000_00000000) begin
      testsFailed++; $display("[TB] FAIL midrst_shadow_clear: got %h", data_o);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_single_frame();
    test_led_ordering();
    test_write_with_commit();
    test_busy_collapse();
    test_back_to_back();
    test_frame_cnt_wrap();
    test_auto_refresh();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
